// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Purpose  : Multi-port register file with write-back bypass, PC-alias reads
//             of the top register, and a per-register busy scoreboard that
//             issue allocates and write-back releases.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int PC_OFS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*DW-1:0]   o_rd_data,
    output logic [NRD-1:0]      o_rd_rdy,
    input  logic [NWR-1:0]      i_wb_en,
    input  logic [NWR*AW-1:0]   i_wb_addr,
    input  logic [NWR*DW-1:0]   i_wb_data,
    input  logic [NWR-1:0]      i_alloc_en,
    input  logic [NWR*AW-1:0]   i_alloc_addr,
    input  logic                i_flush,
    input  logic [DW-1:0]       i_pc,
    output logic [(2**AW)-1:0]  o_busy
);

    localparam int             NREG      = 2**AW;
    localparam logic [AW-1:0]  c_PC_ADDR = {AW{1'b1}};

    // Only NREG-1 physical registers: the top address is the PC alias.
    logic [DW-1:0]    r_mem [0:NREG-2];
    logic [NREG-2:0]  r_busy;

    logic [NREG-2:0]  w_alloc_hit;
    logic [NREG-2:0]  w_wb_hit;
    logic [DW-1:0]    w_pc_val;
    logic [NREG-1:0]  w_busy_full;

    assign w_pc_val    = i_pc + DW'(PC_OFS);
    assign w_busy_full = {1'b0, r_busy};
    assign o_busy      = w_busy_full;

    // Per-register decode of which allocate / write-back ports target it.
    always_comb begin
        w_alloc_hit = '0;
        w_wb_hit    = '0;
        for (int r = 0; r < NREG-1; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (i_alloc_en[j] && (i_alloc_addr[j*AW +: AW] == AW'(r)))
                    w_alloc_hit[r] = 1'b1;
                if (i_wb_en[j] && (i_wb_addr[j*AW +: AW] == AW'(r)))
                    w_wb_hit[r] = 1'b1;
            end
        end
    end

    // Storage write: ports visited in ascending order so the highest index wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG-1; r++)
                r_mem[r] <= '0;
        end else begin
            for (int r = 0; r < NREG-1; r++) begin
                for (int j = 0; j < NWR; j++) begin
                    if (i_wb_en[j] && (i_wb_addr[j*AW +: AW] == AW'(r)))
                        r_mem[r] <= i_wb_data[j*DW +: DW];
                end
            end
        end
    end

    // Busy scoreboard: flush beats allocate, allocate beats release (a new
    // producer supersedes the one completing this cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else if (i_flush) begin
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREG-1; r++) begin
                if (w_alloc_hit[r])
                    r_busy[r] <= 1'b1;
                else if (w_wb_hit[r])
                    r_busy[r] <= 1'b0;
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd_port
            logic [AW-1:0] w_addr;
            logic          w_hit;
            logic [DW-1:0] w_byp;
            logic [DW-1:0] w_data;
            logic          w_rdy;

            assign w_addr = i_rd_addr[k*AW +: AW];

            // Same-cycle bypass search; the last matching port wins.
            always_comb begin
                w_hit = 1'b0;
                w_byp = '0;
                for (int j = 0; j < NWR; j++) begin
                    if (i_wb_en[j] && (i_wb_addr[j*AW +: AW] == w_addr)) begin
                        w_hit = 1'b1;
                        w_byp = i_wb_data[j*DW +: DW];
                    end
                end
            end

            // Read mux and operand-ready: PC alias, then bypass, then storage.
            always_comb begin
                w_data = '0;
                w_rdy  = 1'b0;
                if (w_addr == c_PC_ADDR) begin
                    w_data = w_pc_val;
                    w_rdy  = 1'b1;
                end else begin
                    w_data = w_hit ? w_byp : r_mem[w_addr];
                    w_rdy  = w_hit || !w_busy_full[w_addr];
                end
            end

            assign o_rd_data[k*DW +: DW] = w_data;
            assign o_rd_rdy[k]           = w_rdy;
        end
    endgenerate

endmodule
`default_nettype wire
